servant_spi_slave: RTL and testbench

SPI mode-0 slave front end that decodes serial RAM commands from an external master. It drives the byte-wide RAM port of servant_spi_ram (address, write data, active-low write strobe, read enable) and returns read data on MISO. All SPI inputs are oversampled and synchronised into i_clk, so SCLK is never used as a clock. It sits directly upstream of servant_spi_ram, between the board SPI pins and the RAM.

---
 rtl/servant_spi_pkg.sv | 20 ++
 rtl/servant_spi_slave_if.sv | 29 ++
 rtl/servant_spi_sync.sv | 37 +++
 rtl/servant_spi_slave.sv | 160 ++++++++++++++++
 tb/tb_servant_spi_slave.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/servant_spi_pkg.sv
// Shared opcodes, states and constants
// for the servant SPI RAM front end.
package servant_spi_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  // i_clk must run at least this many times faster than SCLK
  localparam int MIN_OVERSAMPLE = 4;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } state_e;

endpackage

// File: rtl/servant_spi_slave_if.sv
// Byte-wide RAM port between the SPI slave
// and servant_spi_ram.
interface servant_spi_slave_if #(
  parameter int aw = 16
);

  logic [aw-1:0] o_addr;
  logic [7:0]    o_wdata;
  logic          o_we_n;
  logic          o_re;
  logic [7:0]    i_rdata;

  modport master (
    output o_addr,
    output o_wdata,
    output o_we_n,
    output o_re,
    input  i_rdata
  );

  modport slave (
    input  o_addr,
    input  o_wdata,
    input  o_we_n,
    input  o_re,
    output i_rdata
  );

endinterface

// File: rtl/servant_spi_sync.sv
// Two-flop synchronisers for the SPI pins
// plus SCLK edge detection in i_clk.
module servant_spi_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_n_s_o,
  output logic mosi_s_o
);

  logic [2:0] sclk_q;
  logic [1:0] cs_n_q;
  logic [1:0] mosi_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_q <= '0;
      cs_n_q <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], i_sclk};
      cs_n_q <= {cs_n_q[0], i_cs_n};
      mosi_q <= {mosi_q[0], i_mosi};
    end
  end

  // sclk_q[1] is the synced level, sclk_q[2] its previous value
  assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_o = ~sclk_q[1] & sclk_q[2];
  assign cs_n_s_o    = cs_n_q[1];
  assign mosi_s_o    = mosi_q[1];

endmodule

// File: rtl/servant_spi_slave.sv
// SPI mode-0 slave decoding serial RAM
// read/write commands onto a byte RAM port.
module servant_spi_slave
  import servant_spi_pkg::*;
#(
  parameter int depth      = 65536,
  parameter int aw         = $clog2(depth),
  parameter int ADDR_BYTES = (aw + 7) / 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_miso,
  servant_spi_slave_if.master ram
);

  localparam int AB  = 8 * ADDR_BYTES;
  localparam int ABW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  logic rise, fall, cs_n_s, mosi_s;

  servant_spi_sync u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sclk     (i_sclk),
    .i_cs_n     (i_cs_n),
    .i_mosi     (i_mosi),
    .sclk_rise_o(rise),
    .sclk_fall_o(fall),
    .cs_n_s_o   (cs_n_s),
    .mosi_s_o   (mosi_s)
  );

  state_e        state_q;
  logic [2:0]    bit_q;
  logic [ABW-1:0] abyte_q;
  logic [7:0]    sh_q;
  logic [AB-1:0] ash_q;
  logic [7:0]    tx_q;
  logic          wr_q;
  logic          inc_q;
  logic          miso_q;
  logic [aw-1:0] addr_q;
  logic [7:0]    wdata_q;
  logic          we_n_q;
  logic          re_q;

  logic [7:0]    sh_d;
  logic [AB-1:0] ash_d;

  assign sh_d  = {sh_q[6:0], mosi_s};
  assign ash_d = {ash_q[AB-2:0], mosi_s};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      abyte_q <= '0;
      sh_q    <= '0;
      ash_q   <= '0;
      tx_q    <= '0;
      wr_q    <= 1'b0;
      inc_q   <= 1'b0;
      miso_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      re_q    <= 1'b0;
    end else begin
      we_n_q <= 1'b1;
      re_q   <= 1'b0;
      // a committed write always advances the address
      if (inc_q) begin
        addr_q <= addr_q + 1'b1;
        inc_q  <= 1'b0;
      end
      if (re_q) tx_q <= ram.i_rdata;
      if (cs_n_s) begin
        state_q <= IDLE;
        bit_q   <= '0;
        abyte_q <= '0;
        miso_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            bit_q   <= '0;
            abyte_q <= '0;
            state_q <= CMD;
          end
          CMD: if (rise) begin
            sh_q  <= sh_d;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              abyte_q <= '0;
              if (sh_d == CMD_WRITE) begin
                wr_q    <= 1'b1;
                state_q <= ADDR;
              end else if (sh_d == CMD_READ) begin
                wr_q    <= 1'b0;
                state_q <= ADDR;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          ADDR: if (rise) begin
            ash_q <= ash_d;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (abyte_q == ABW'(ADDR_BYTES - 1)) begin
                addr_q <= ash_d[aw-1:0];
                if (wr_q) begin
                  state_q <= WDATA;
                end else begin
                  re_q    <= 1'b1;
                  state_q <= RDATA;
                end
              end else begin
                abyte_q <= abyte_q + ABW'(1);
              end
            end
          end
          WDATA: if (rise) begin
            sh_q  <= sh_d;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              wdata_q <= sh_d;
              we_n_q  <= 1'b0;
              inc_q   <= 1'b1;
            end
          end
          RDATA: begin
            if (fall) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
            if (rise) begin
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                addr_q <= addr_q + 1'b1;
                re_q   <= 1'b1;
              end
            end
          end
          IGNORE: miso_q <= 1'b0;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_miso      = miso_q;
  assign ram.o_addr  = addr_q;
  assign ram.o_wdata = wdata_q;
  assign ram.o_we_n  = we_n_q;
  assign ram.o_re    = re_q;

endmodule

// File: tb/tb_servant_spi_slave.sv
// Directed bench for servant_spi_slave with
// a behavioural RAM on the interface.
module tb_servant_spi_slave;
  import servant_spi_pkg::*;

  logic clk = 1'b0;
  logic rst, sclk, cs_n, mosi, miso;

  servant_spi_slave_if #(.aw(16)) bus ();

  servant_spi_slave #(.depth(65536)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_sclk(sclk),
    .i_cs_n(cs_n),
    .i_mosi(mosi),
    .o_miso(miso),
    .ram   (bus)
  );

  always #5 clk = ~clk;

  bit [7:0] mem [65536];
  assign bus.i_rdata = mem[bus.o_addr];

  int we_cnt = 0;
  int re_cnt = 0;
  int miso_cnt = 0;
  logic [15:0] last_waddr = '0;
  logic [7:0]  last_wdata = '0;

  always @(negedge clk) begin
    if (bus.o_we_n === 1'b0) begin
      we_cnt++;
      last_waddr = bus.o_addr;
      last_wdata = bus.o_wdata;
      mem[bus.o_addr] = bus.o_wdata;
    end
    if (bus.o_re === 1'b1) re_cnt++;
    if (miso === 1'b1) miso_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic spi_bits(input logic [7:0] v, input int n,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = v[i];
      #40;
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] v, output logic [7:0] rx);
    spi_bits(v, 8, rx);
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_end();
    #80;
    cs_n = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (miso !== 1'b0) begin
      errors++; $display("FAIL reset_miso got %b want 0", miso);
    end
    checks++;
    if (bus.o_addr !== 16'h0000) begin
      errors++; $display("FAIL reset_addr got %h want 0000", bus.o_addr);
    end
    checks++;
    if (bus.o_wdata !== 8'h00) begin
      errors++; $display("FAIL reset_wdata got %h want 00", bus.o_wdata);
    end
    checks++;
    if (bus.o_we_n !== 1'b1) begin
      errors++; $display("FAIL reset_we_n got %b want 1", bus.o_we_n);
    end
    checks++;
    if (bus.o_re !== 1'b0) begin
      errors++; $display("FAIL reset_re got %b want 0", bus.o_re);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] rx;
    int w0;
    w0 = we_cnt;
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h12, rx);
    spi_byte(8'h34, rx);
    spi_byte(8'hA5, rx);
    cs_end();
    checks++;
    if (we_cnt - w0 !== 1) begin
      errors++; $display("FAIL write_pulses got %0d want 1", we_cnt - w0);
    end
    checks++;
    if (last_waddr !== 16'h1234) begin
      errors++; $display("FAIL write_addr got %h want 1234", last_waddr);
    end
    checks++;
    if (last_wdata !== 8'hA5) begin
      errors++; $display("FAIL write_data got %h want a5", last_wdata);
    end
    checks++;
    if (mem[16'h1234] !== 8'hA5) begin
      errors++; $display("FAIL write_mem got %h want a5", mem[16'h1234]);
    end
  endtask

  task automatic test_read();
    logic [7:0] rx;
    int r0, w0;
    r0 = re_cnt;
    w0 = we_cnt;
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h12, rx);
    spi_byte(8'h34, rx);
    checks++;
    if (re_cnt - r0 !== 1) begin
      errors++; $display("FAIL read_prefetch got %0d want 1", re_cnt - r0);
    end
    spi_byte(8'h00, rx);
    checks++;
    if (rx !== 8'hA5) begin
      errors++; $display("FAIL read_data got %h want a5", rx);
    end
    #40;
    checks++;
    if (bus.o_addr !== 16'h1235) begin
      errors++; $display("FAIL read_addr got %h want 1235", bus.o_addr);
    end
    cs_end();
    checks++;
    if (we_cnt - w0 !== 0) begin
      errors++; $display("FAIL read_no_write got %0d want 0", we_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx;
    logic [7:0] exp [3];
    int w0;
    exp = '{8'h11, 8'h22, 8'h33};
    w0 = we_cnt;
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'hFF, rx);
    spi_byte(8'hFE, rx);
    for (int i = 0; i < 3; i++) spi_byte(exp[i], rx);
    cs_end();
    checks++;
    if (we_cnt - w0 !== 3) begin
      errors++; $display("FAIL burst_pulses got %0d want 3", we_cnt - w0);
    end
    checks++;
    if (mem[16'hFFFE] !== 8'h11) begin
      errors++; $display("FAIL burst_fffe got %h want 11", mem[16'hFFFE]);
    end
    checks++;
    if (mem[16'hFFFF] !== 8'h22) begin
      errors++; $display("FAIL burst_ffff got %h want 22", mem[16'hFFFF]);
    end
    checks++;
    if (mem[16'h0000] !== 8'h33) begin
      errors++; $display("FAIL burst_0000 got %h want 33", mem[16'h0000]);
    end
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'hFF, rx);
    spi_byte(8'hFE, rx);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'h00, rx);
      checks++;
      if (rx !== exp[i]) begin
        errors++;
        $display("FAIL burst_read%0d got %h want %h", i, rx, exp[i]);
      end
    end
    cs_end();
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int w0;
    w0 = we_cnt;
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_bits(8'h77, 5, rx);
    cs_end();
    checks++;
    if (we_cnt - w0 !== 0) begin
      errors++; $display("FAIL abort_pulses got %0d want 0", we_cnt - w0);
    end
    checks++;
    if (mem[16'h0010] !== 8'h00) begin
      errors++; $display("FAIL abort_mem got %h want 00", mem[16'h0010]);
    end
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_byte(8'h77, rx);
    cs_end();
    checks++;
    if (we_cnt - w0 !== 1) begin
      errors++; $display("FAIL abort_next_pulses got %0d want 1", we_cnt - w0);
    end
    checks++;
    if (mem[16'h0010] !== 8'h77) begin
      errors++; $display("FAIL abort_next_mem got %h want 77", mem[16'h0010]);
    end
  endtask

  task automatic test_unknown();
    logic [7:0] rx;
    logic [7:0] acc;
    int w0, r0, m0;
    w0 = we_cnt; r0 = re_cnt; m0 = miso_cnt;
    acc = '0;
    cs_begin();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'hFF, rx);
      acc = acc | rx;
    end
    cs_end();
    checks++;
    if (acc !== 8'h00) begin
      errors++; $display("FAIL unk_rx got %h want 00", acc);
    end
    checks++;
    if (we_cnt - w0 !== 0) begin
      errors++; $display("FAIL unk_we got %0d want 0", we_cnt - w0);
    end
    checks++;
    if (re_cnt - r0 !== 0) begin
      errors++; $display("FAIL unk_re got %0d want 0", re_cnt - r0);
    end
    checks++;
    if (miso_cnt - m0 !== 0) begin
      errors++; $display("FAIL unk_miso got %0d want 0", miso_cnt - m0);
    end
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_byte(8'h00, rx);
    cs_end();
    checks++;
    if (rx !== 8'h77) begin
      errors++; $display("FAIL unk_next_read got %h want 77", rx);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    int w0;
    w0 = we_cnt;
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h20, rx);
    spi_bits(8'hFF, 6, rx);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_we_n !== 1'b1) begin
      errors++; $display("FAIL rmid_we_n got %b want 1", bus.o_we_n);
    end
    checks++;
    if (bus.o_re !== 1'b0) begin
      errors++; $display("FAIL rmid_re got %b want 0", bus.o_re);
    end
    checks++;
    if (bus.o_addr !== 16'h0000) begin
      errors++; $display("FAIL rmid_addr got %h want 0000", bus.o_addr);
    end
    checks++;
    if (bus.o_wdata !== 8'h00) begin
      errors++; $display("FAIL rmid_wdata got %h want 00", bus.o_wdata);
    end
    checks++;
    if (miso !== 1'b0) begin
      errors++; $display("FAIL rmid_miso got %b want 0", miso);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL rmid_state got %0d want %0d", dut.state_q, IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    cs_n = 1'b1;
    #200;
    checks++;
    if (we_cnt - w0 !== 0) begin
      errors++; $display("FAIL rmid_pulses got %0d want 0", we_cnt - w0);
    end
    checks++;
    if (mem[16'h0020] !== 8'h00) begin
      errors++; $display("FAIL rmid_mem got %h want 00", mem[16'h0020]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_abort();
    test_unknown();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
